// File: rtl/printer_fifo.sv
// rtl/printer_fifo.sv - Z80 printer-port byte FIFO with ESP drain notify and status byte.
// Optional PRINTER_BUSY_STATUS_EN reports full as busy on status bit7.
module printer_fifo #(
    parameter int DEPTH_LOG2  = 6,
    parameter int THRESH      = 16,
    parameter int IDLE_CYCLES = 840000
) (
    input  logic                  clk,
    input  logic                  RST_N,
    input  logic                  wr_stb,
    input  logic [7:0]            wr_data,
    input  logic                  pop_stb,
    output logic [7:0]            pop_data,
    input  logic                  flush,
    input  logic                  clr_ovf,
    output logic [7:0]            status,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  notify
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IW    = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FILL, NOTIFY} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [DEPTH_LOG2:0]   count_next;
    logic [IW-1:0]         idle_cnt, idle_next;
    state_t                state, state_next;
    logic                  push_ok, pop_ok, drop, busy;

    assign empty      = (count == '0);
    assign full       = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign rd_ptr_inc = rd_ptr + 1'b1;

    // flush outranks both strobes; a pop frees the slot a full-FIFO push needs
    assign pop_ok  = pop_stb && !empty && !flush;
    assign push_ok = wr_stb && (!full || pop_ok) && !flush;
    assign drop    = wr_stb && !push_ok && !flush;

    always_comb begin
        count_next = count + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop_ok};
        if (flush)
            count_next = '0;
    end

`ifdef PRINTER_BUSY_STATUS_EN
    assign busy = (count_next == (DEPTH_LOG2+1)'(DEPTH));
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= 8'h00;
            overflow <= 1'b0;
            status   <= 8'h30;
        end else begin
            count  <= count_next;
            status <= {busy, 7'h30};
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)
                    rd_ptr <= rd_ptr_inc;
                if (drop)
                    overflow <= 1'b1;
                else if (clr_ovf)
                    overflow <= 1'b0;
                // the head register is refilled from the write bus when the new head is the byte being written
                if (push_ok && (empty || (pop_ok && count == (DEPTH_LOG2+1)'(1))))
                    pop_data <= wr_data;
                else if (pop_ok && count > (DEPTH_LOG2+1)'(1))
                    pop_data <= mem[rd_ptr_inc];
            end
        end
    end

    always_comb begin
        state_next = state;
        idle_next  = idle_cnt;
        case (state)
            IDLE: begin
                idle_next = '0;
                if (push_ok)
                    state_next = FILL;
            end
            FILL: begin
                idle_next = push_ok ? '0 : idle_cnt + 1'b1;
                if (count_next == '0)
                    state_next = IDLE;
                else if (count_next >= (DEPTH_LOG2+1)'(THRESH) || idle_cnt == IW'(IDLE_CYCLES - 1))
                    state_next = NOTIFY;
            end
            NOTIFY: begin
                idle_next = '0;
                if (count_next == '0)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idle_next  = '0;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
            idle_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            idle_cnt <= '0;
            notify   <= 1'b0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
            notify   <= (state == NOTIFY) && !flush;
        end
    end
endmodule
